// File: rtl/cpu_clk_ctrl_if.sv
// rtl/cpu_clk_ctrl_if.sv - board/CPU-side signal bundle for the CPU clock controller
interface cpu_clk_ctrl_if;
    logic        go_btn;
    logic        step_btn;
    logic [1:0]  speed_sel;
    logic        halt_req;
    logic        cpu_en;
    logic [1:0]  state;
    logic [31:0] cycle_cnt;

    // Board / CPU side: drives the controls, observes the tick
    modport master (
        output go_btn, step_btn, speed_sel, halt_req,
        input  cpu_en, state, cycle_cnt
    );

    // Controller side
    modport slave (
        input  go_btn, step_btn, speed_sel, halt_req,
        output cpu_en, state, cycle_cnt
    );
endinterface

// File: rtl/cpu_clk_ctrl.sv
// rtl/cpu_clk_ctrl.sv - run/step/halt controller producing the CPU clock-enable tick
module cpu_clk_ctrl #(
    parameter int unsigned P_SLOW    = 100_000_000,
    parameter int unsigned P_MED     = 10_000_000,
    parameter int unsigned P_FAST    = 1_000,
    parameter int unsigned DB_CYCLES = 1_000_000
) (
    input  logic          clk,
    input  logic          rst,
    cpu_clk_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        S_HALT = 2'b00,
        S_RUN  = 2'b01,
        S_STEP = 2'b10
    } state_t;

    // Periods are stored minus one so the tick comparison is a plain >=
    localparam logic [31:0] SLOW_M1 = 32'(P_SLOW - 1);
    localparam logic [31:0] MED_M1  = 32'(P_MED - 1);
    localparam logic [31:0] FAST_M1 = 32'(P_FAST - 1);
    localparam logic [31:0] DB_LAST = 32'(DB_CYCLES - 1);

    // Bit 0 is the go button, bit 1 the step button
    logic [1:0]  sync1;
    logic [1:0]  sync2;
    logic [1:0]  db_level;
    logic [1:0]  db_prev;
    logic [1:0]  btn_p;
    logic [31:0] db_cnt [2];

    logic        halt_d;
    logic        halt_p;

    state_t      cur;
    logic [31:0] tick_cnt;
    logic [31:0] period_m1;
    logic        cpu_en_q;
    logic [31:0] cycle_cnt_q;

    logic        go_p;
    logic        step_p;

    assign go_p   = btn_p[0];
    assign step_p = btn_p[1];

    // Synchronize, debounce and edge-detect both buttons
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            db_level <= '0;
            db_prev  <= '0;
            btn_p    <= '0;
            for (int i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync1   <= {bus.step_btn, bus.go_btn};
            sync2   <= sync1;
            db_prev <= db_level;
            btn_p   <= db_level & ~db_prev;
            for (int i = 0; i < 2; i++) begin
                // A sample matching the current level means the run of differing samples broke
                if (sync2[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] >= DB_LAST) begin
                    db_level[i] <= sync2[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 32'd1;
                end
            end
        end
    end

    // Registered rising-edge detect of the CPU halt request
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_d <= 1'b0;
            halt_p <= 1'b0;
        end else begin
            halt_d <= bus.halt_req;
            halt_p <= bus.halt_req & ~halt_d;
        end
    end

    // Tick period follows speed_sel live so a shorter period takes effect at once
    always_comb begin
        period_m1 = '0;
        case (bus.speed_sel)
            2'd0:    period_m1 = '0;
            2'd1:    period_m1 = SLOW_M1;
            2'd2:    period_m1 = MED_M1;
            default: period_m1 = FAST_M1;
        endcase
    end

    // Run/step/halt state machine with registered tick and pulse counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur         <= S_HALT;
            tick_cnt    <= '0;
            cpu_en_q    <= 1'b0;
            cycle_cnt_q <= '0;
        end else begin
            cpu_en_q <= 1'b0;
            case (cur)
                S_HALT: begin
                    if (go_p) begin
                        cur      <= S_RUN;
                        tick_cnt <= '0;
                    end else if (step_p) begin
                        cur <= S_STEP;
                    end
                end
                S_RUN: begin
                    if (go_p || halt_p) begin
                        cur <= S_HALT;
                    end else if (tick_cnt >= period_m1) begin
                        cpu_en_q    <= 1'b1;
                        tick_cnt    <= '0;
                        cycle_cnt_q <= cycle_cnt_q + 32'd1;
                    end else begin
                        tick_cnt <= tick_cnt + 32'd1;
                    end
                end
                S_STEP: begin
                    cpu_en_q    <= 1'b1;
                    cycle_cnt_q <= cycle_cnt_q + 32'd1;
                    cur         <= S_HALT;
                end
                default: begin
                    cur <= S_HALT;
                end
            endcase
        end
    end

    assign bus.cpu_en    = cpu_en_q;
    assign bus.state     = cur;
    assign bus.cycle_cnt = cycle_cnt_q;

endmodule

// File: doc/cpu_clk_ctrl.md
# cpu_clk_ctrl

Run/step/halt controller for the single-cycle CPU clock. It turns the board buttons, a speed selector and a CPU halt request into a one-cycle clock-enable pulse, `cpu_en`, which gates every CPU state element. It sits between the board I/O and the CPU datapath, and it replaces free-running division of the board clock with a controlled, countable tick.

## Interface
Parameters:
- `P_SLOW`, default 100_000_000: tick period in `clk` cycles for `speed_sel=1`.
- `P_MED`, default 10_000_000: tick period for `speed_sel=2`.
- `P_FAST`, default 1_000: tick period for `speed_sel=3`.
- `DB_CYCLES`, default 1_000_000: debounce stability window in `clk` cycles.
- All parameters are ≥1 and fit in 32 bits. `speed_sel=0` has a fixed period of 1.

Ports:
- `clk  in  1`: system clock.
- `rst  in  1`: reset, asynchronous, active-high.
- `go_btn  in  1`: raw run/pause button, asynchronous, bouncing.
- `step_btn  in  1`: raw single-step button, asynchronous, bouncing.
- `speed_sel  in  2`: period select.
- `halt_req  in  1`: level from the CPU (halt syscall), synchronous to `clk`.
- `cpu_en  out  1`: registered one-cycle tick.
- `state  out  2`: `00` HALT, `01` RUN, `10` STEP.
- `cycle_cnt  out  32`: number of `cpu_en` pulses issued.

## Operation
- **Button path (per button):**
  - A 2-FF synchronizer feeds a debounce counter.
  - The debounced level takes the synchronized value after that value has been stable for `DB_CYCLES` consecutive cycles. Any change restarts the count.
  - A rising edge of the debounced level gives a one-cycle pulse (`go_p`, `step_p`).
- **halt_req:** rising-edge detected (`halt_p`). A held-high level does not re-halt the controller after a resume.
- **Period:** `P` is 1, `P_SLOW`, `P_MED` or `P_FAST` according to the current `speed_sel`.
- **State machine:**
  - HALT:
    - `go_p` → RUN, with `tick_cnt` cleared to 0.
    - Otherwise `step_p` → STEP.
    - `go_p` wins if both pulses arrive together.
  - RUN:
    - `go_p` or `halt_p` → HALT. No `cpu_en` is issued on that edge.
    - `step_p` is ignored.
  - STEP: unconditionally issues one `cpu_en`, then → HALT. All pulses are ignored.
- **Tick counter (RUN only):**
  - At each edge in RUN with no stop event: if `tick_cnt >= P-1`, then `cpu_en <= 1` and `tick_cnt <= 0`. Otherwise `cpu_en <= 0` and `tick_cnt <= tick_cnt+1`.
  - The `>=` comparison makes a mid-run change to a shorter period fire on the next edge.
- **cycle_cnt:** increments on every edge where `cpu_en` is registered high. It wraps from 2^32-1 to 0.
- `cpu_en` is 0 in every state and cycle not listed above.

## Timing
- **Reset values:** `cpu_en=0`, `state=HALT`, `cycle_cnt=0`, `tick_cnt=0`, synchronizers and debounced levels 0, edge detectors 0.
- **Reset mid-operation:** outputs clear immediately. A button held through reset is seen as a fresh press, giving one pulse `DB_CYCLES+3` cycles after release.
- **Button latency:** from a clean input edge to the pulse is 2 (sync) + `DB_CYCLES` + 1 cycles. The state changes on the edge where the pulse is high.
- **RUN:** the first `cpu_en` is high P cycles after `state` becomes RUN. Subsequent pulses are exactly P cycles apart. With P=1, `cpu_en` is high every cycle starting 1 cycle after RUN entry.
- **STEP:** `state=STEP` for exactly 1 cycle, then `cpu_en=1` for exactly 1 cycle, coincident with `state=HALT`.
- **halt_req:** `halt_p` is registered, so HALT is entered 2 edges after `halt_req` rises. At most one `cpu_en` can occur in between.
- `cpu_en` is never high for two consecutive cycles unless P=1 in RUN.

## Test plan
All scenarios use `P_SLOW=8`, `P_MED=4`, `P_FAST=2`, `DB_CYCLES=4`.
- **Reset:** assert `rst` asynchronously between edges → `cpu_en=0`, `state=00`, `cycle_cnt=0` immediately. Hold buttons low for 20 cycles → no change.
- **Debounce/step:** `step_btn` glitches of 1–3 cycles → no pulse. A clean press held for 10 cycles → `state=10` for 1 cycle, then exactly one `cpu_en`, `cycle_cnt=1`, `state=00`.
- **Run at P=4:** `speed_sel=2`, press `go_btn` → `state=01`. `cpu_en` first fires 4 cycles later, then every 4 cycles; `cycle_cnt=5` after 20 RUN cycles. A second `go` press → `state=00`, and `cycle_cnt` stays frozen.
- **Halt:** in RUN, raise `halt_req` and hold it → `state=00` within 2 edges, no further `cpu_en`. A `go` press while `halt_req` is still high → RUN resumes and ticks continue.
- **Speed change:** in RUN with `speed_sel=1`, change to 3 when `tick_cnt=5` → `cpu_en` on the next edge, then every 2 cycles. Also check `speed_sel=0` → `cpu_en` high every cycle.
- **Reset mid-run / wrap:** `rst` during RUN with `cycle_cnt=7` → immediate HALT, `cycle_cnt=0`. Force `cycle_cnt` to 32'hFFFFFFFF and issue one step → `cycle_cnt=0`.
